// File: rtl/adc_frame_capture.sv
// DDR ADC frame grabber: captures PIX_NUM pixels per frame, packs pixel pairs into RAM words, rotates over NUM_BUF frame buffers.
// Optional build macro ADC_FRAME_TEST_PATTERN_EN swaps captured ADC data for a per-frame pixel counter.
module adc_frame_capture #(
  parameter int          LANE_W    = 8,
  parameter int          PIX_NUM   = 512,
  parameter int          ADC_LAT   = 4,
  parameter int          NUM_BUF   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                abort_i,
  output logic                adc_clk_o,
  input  logic [LANE_W-1:0]   adc_data_i,
  output logic                adc_oeb_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                overrun_o,
  output logic [7:0]          frame_idx_o,
  output logic                ram_wr_o,
  output logic [31:0]         ram_addr_o,
  output logic [4*LANE_W-1:0] ram_data_o
);

  localparam int          PIX_W       = 2 * LANE_W;
  localparam logic [31:0] FRAME_BYTES = 32'(4 * ((PIX_NUM + 1) / 2));
  localparam logic [15:0] LAT_LAST    = 16'(ADC_LAT - 1);
  localparam logic [15:0] PIX_LAST    = 16'(PIX_NUM - 1);
  localparam logic [7:0]  BUF_LAST    = 8'(NUM_BUF - 1);
  localparam bit          PIX_ODD     = (PIX_NUM % 2) == 1;

  typedef enum logic [1:0] {S_IDLE, S_LAT_WAIT, S_CAPTURE, S_FLUSH} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [15:0]         r_cnt;
  logic [LANE_W-1:0]   r_rise;
  logic [LANE_W-1:0]   r_fall;
  logic [PIX_W-1:0]    r_hold;
  logic [PIX_W-1:0]    w_pixel;
  logic [4*LANE_W-1:0] w_word;
  logic [4*LANE_W-1:0] r_data;
  logic [31:0]         r_addr;
  logic [31:0]         r_next_addr;
  logic [31:0]         r_frame_base;
  logic [7:0]          r_frame_idx;
  logic                r_wr;
  logic                r_done;
  logic                r_overrun;
  logic                w_busy;
  logic                w_start_ok;
  logic                w_capture;
  logic                w_issue;
  logic                w_complete;

  assign adc_clk_o = clk;

  // Both halves of one clk period are held until the following rising edge consumes them as one pixel.
  always_ff @(posedge clk) r_rise <= adc_data_i;
  always_ff @(negedge clk) r_fall <= adc_data_i;

`ifdef ADC_FRAME_TEST_PATTERN_EN
  logic [PIX_W-1:0] r_pat;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_pat <= '0;
    else if (w_start_ok)
      r_pat <= '0;
    else if (r_state == S_CAPTURE)
      r_pat <= r_pat + 1'b1;
  end

  assign w_pixel = r_pat;
`else
  assign w_pixel = {r_rise, r_fall};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (abort_i) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:     if (start_i) w_state_next = S_LAT_WAIT;
        S_LAT_WAIT: if (r_cnt == LAT_LAST) w_state_next = S_CAPTURE;
        S_CAPTURE:  if (r_cnt == PIX_LAST) w_state_next = S_FLUSH;
        S_FLUSH:    w_state_next = S_IDLE;
        default:    w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy    = (r_state != S_IDLE);
    adc_oeb_o = ~w_busy;
    busy_o    = w_busy;
  end

  assign w_start_ok = (r_state == S_IDLE) && start_i && !abort_i;
  assign w_capture  = (r_state == S_CAPTURE) && !abort_i;
  // A word is complete on every odd pixel, or on the unpaired last pixel of an odd-length frame.
  assign w_issue    = w_capture && (r_cnt[0] || (PIX_ODD && (r_cnt == PIX_LAST)));
  assign w_word     = r_cnt[0] ? {r_hold, w_pixel} : {w_pixel, {PIX_W{1'b0}}};
  assign w_complete = (r_state == S_FLUSH) && !abort_i;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (r_state != w_state_next)
      r_cnt <= '0;
    else if (w_busy)
      r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr         <= 1'b0;
      r_done       <= 1'b0;
      r_data       <= '0;
      r_hold       <= '0;
      r_addr       <= BASE_ADDR;
      r_next_addr  <= BASE_ADDR;
      r_frame_base <= BASE_ADDR;
      r_frame_idx  <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_wr   <= w_issue;
      r_done <= w_complete;
      if (w_start_ok) begin
        r_next_addr <= r_frame_base;
        r_overrun   <= 1'b0;
      end else if (start_i && w_busy) begin
        r_overrun <= 1'b1;
      end
      if (w_capture && !r_cnt[0])
        r_hold <= w_pixel;
      if (w_issue) begin
        r_data      <= w_word;
        r_addr      <= r_next_addr;
        r_next_addr <= r_next_addr + 32'd4;
      end
      if (w_complete) begin
        if (r_frame_idx == BUF_LAST) begin
          r_frame_idx  <= '0;
          r_frame_base <= BASE_ADDR;
        end else begin
          r_frame_idx  <= r_frame_idx + 1'b1;
          r_frame_base <= r_frame_base + FRAME_BYTES;
        end
      end
    end
  end

  assign ram_wr_o    = r_wr;
  assign ram_addr_o  = r_addr;
  assign ram_data_o  = r_data;
  assign done_o      = r_done;
  assign overrun_o   = r_overrun;
  assign frame_idx_o = r_frame_idx;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Bench for adc_frame_capture: two instances (512-pixel even frame, 5-pixel odd frame with offset base), random DDR data
// and frame-level expectations derived from start/abort timing.
module tb_adc_frame_capture;

  localparam int          A_PIX  = 512;
  localparam int          A_LAT  = 4;
  localparam int          A_NB   = 2;
  localparam logic [31:0] A_BASE = 32'h0;
  localparam int          B_PIX  = 5;
  localparam int          B_LAT  = 3;
  localparam int          B_NB   = 3;
  localparam logic [31:0] B_BASE = 32'h100;
  localparam int          NONE   = -1000;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic [7:0]  adc = 8'h0;

  logic        a_adc_clk, a_oeb, a_busy, a_done, a_ovr, a_wr;
  logic [7:0]  a_idx;
  logic [31:0] a_addr, a_data;
  logic        b_adc_clk, b_oeb, b_busy, b_done, b_ovr, b_wr;
  logic [7:0]  b_idx;
  logic [31:0] b_addr, b_data;

  adc_frame_capture #(.LANE_W(8), .PIX_NUM(A_PIX), .ADC_LAT(A_LAT), .NUM_BUF(A_NB), .BASE_ADDR(A_BASE)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a),
    .adc_clk_o(a_adc_clk), .adc_data_i(adc), .adc_oeb_o(a_oeb),
    .busy_o(a_busy), .done_o(a_done), .overrun_o(a_ovr), .frame_idx_o(a_idx),
    .ram_wr_o(a_wr), .ram_addr_o(a_addr), .ram_data_o(a_data)
  );

  adc_frame_capture #(.LANE_W(8), .PIX_NUM(B_PIX), .ADC_LAT(B_LAT), .NUM_BUF(B_NB), .BASE_ADDR(B_BASE)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b),
    .adc_clk_o(b_adc_clk), .adc_data_i(adc), .adc_oeb_o(b_oeb),
    .busy_o(b_busy), .done_o(b_done), .overrun_o(b_ovr), .frame_idx_o(b_idx),
    .ram_wr_o(b_wr), .ram_addr_o(b_addr), .ram_data_o(b_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pixel presented by the ADC during each clk period: rise half before the rising edge, fall half before the falling edge.
  logic [15:0] pix_tab [4096];
  bit          const_mode = 1'b1;

  initial begin
    int nxt;
    forever begin
      @(negedge clk);
      #1;
      nxt = cyc + 1;
      pix_tab[nxt % 4096] = const_mode ? 16'hA53C : 16'($urandom);
      adc = pix_tab[nxt % 4096][15:8];
      @(posedge clk);
      #1;
      adc = pix_tab[cyc % 4096][7:0];
    end
  end

  wr_t wq_a[$], wq_b[$];
  int  dq_a[$], dq_b[$];

  always @(negedge clk) begin
    wr_t e;
    if (a_wr) begin
      e.cyc = cyc; e.addr = a_addr; e.data = a_data;
      wq_a.push_back(e);
    end
    if (b_wr) begin
      e.cyc = cyc; e.addr = b_addr; e.data = b_data;
      wq_b.push_back(e);
    end
    if (a_done) dq_a.push_back(cyc);
    if (b_done) dq_b.push_back(cyc);
  end

  int n_checks = 0;
  int n_errors = 0;
  int fidx_a = 0;
  int fidx_b = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input int sel, input bit v);
    if (sel == 0) start_a = v; else start_b = v;
  endtask

  task automatic drive_abort(input int sel, input bit v);
    if (sel == 0) abort_a = v; else abort_b = v;
  endtask

  task automatic get_st(input int sel, output logic busy, output logic oeb, output logic ovr, output logic [7:0] idx);
    if (sel == 0) begin busy = a_busy; oeb = a_oeb; ovr = a_ovr; idx = a_idx; end
    else begin busy = b_busy; oeb = b_oeb; ovr = b_ovr; idx = b_idx; end
  endtask

  // Expected pixel i of a frame whose capture window begins at cycle cap0.
  function automatic logic [15:0] exp_pix(input int cap0, input int i);
    int c;
    c = cap0 + i;
`ifdef ADC_FRAME_TEST_PATTERN_EN
    exp_pix = 16'(c - cap0);
`else
    exp_pix = pix_tab[c % 4096];
`endif
  endfunction

  // One frame: abort_off / extra_off are cycle offsets from the first capture cycle (NONE = not applied).
  task automatic run_frame(input int sel, input int abort_off, input int extra_off, input string name);
    int npix, lat, nb, fidx, s, cap0, a, ex, nexp, nwords, w;
    logic [31:0] base, fbytes;
    logic [15:0] hi, lo;
    logic busy, oeb, ovr;
    logic [7:0] idx;
    wr_t q[$];
    int dq[$];
    if (sel == 0) begin
      npix = A_PIX; lat = A_LAT; nb = A_NB; base = A_BASE; fidx = fidx_a;
    end else begin
      npix = B_PIX; lat = B_LAT; nb = B_NB; base = B_BASE; fidx = fidx_b;
    end
    wq_a.delete(); wq_b.delete(); dq_a.delete(); dq_b.delete();
    fbytes = 32'(4 * ((npix + 1) / 2));
    nwords = (npix + 1) / 2;
    tick();
    drive_start(sel, 1'b1);
    s = cyc + 1;
    tick();
    drive_start(sel, 1'b0);
    cap0 = s + lat;
    a  = (abort_off == NONE) ? (1 << 30) : cap0 + abort_off;
    ex = (extra_off == NONE) ? -1 : cap0 + extra_off;
    get_st(sel, busy, oeb, ovr, idx);
    check({name, "_busy_at_start"}, 64'(busy), 64'd1);
    check({name, "_oeb_at_start"}, 64'(oeb), 64'd0);
    check({name, "_ovr_cleared"}, 64'(ovr), 64'd0);
    while (cyc < cap0 + npix + 3) begin
      drive_abort(sel, cyc == a);
      drive_start(sel, cyc == ex);
      tick();
    end
    drive_abort(sel, 1'b0);
    drive_start(sel, 1'b0);
    if (sel == 0) begin q = wq_a; dq = dq_a; end else begin q = wq_b; dq = dq_b; end
    nexp = 0;
    for (int k = 0; k < nwords; k++) begin
      w = (2 * k + 1 < npix) ? cap0 + 2 * k + 2 : cap0 + npix;
      if (w <= a) nexp++;
    end
    check({name, "_num_writes"}, 64'(q.size()), 64'(nexp));
    for (int k = 0; k < nexp && k < q.size(); k++) begin
      w  = (2 * k + 1 < npix) ? cap0 + 2 * k + 2 : cap0 + npix;
      hi = exp_pix(cap0, 2 * k);
      lo = (2 * k + 1 < npix) ? exp_pix(cap0, 2 * k + 1) : 16'h0;
      check($sformatf("%s_wr%0d_cycle", name, k), 64'(q[k].cyc), 64'(w));
      check($sformatf("%s_wr%0d_addr", name, k), 64'(q[k].addr), 64'(base + 32'(fidx) * fbytes + 32'(4 * k)));
      check($sformatf("%s_wr%0d_data", name, k), 64'(q[k].data), 64'({hi, lo}));
    end
    if (a > cap0 + npix) begin
      check({name, "_done_count"}, 64'(dq.size()), 64'd1);
      if (dq.size() >= 1) check({name, "_done_cycle"}, 64'(dq[0]), 64'(cap0 + npix + 1));
      fidx = (fidx + 1) % nb;
    end else begin
      check({name, "_no_done"}, 64'(dq.size()), 64'd0);
    end
    get_st(sel, busy, oeb, ovr, idx);
    check({name, "_frame_idx"}, 64'(idx), 64'(fidx));
    check({name, "_busy_end"}, 64'(busy), 64'd0);
    check({name, "_oeb_end"}, 64'(oeb), 64'd1);
    check({name, "_overrun"}, 64'(ovr), 64'(extra_off != NONE));
    if (sel == 0) fidx_a = fidx; else fidx_b = fidx;
    $display("frame %s dut=%0d start_cycle=%0d writes=%0d done=%0d frame_idx=%0d", name, sel, s, q.size(), dq.size(), idx);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"}, 64'(a_busy), 64'd0);
    check({tag, "_oeb"}, 64'(a_oeb), 64'd1);
    check({tag, "_done"}, 64'(a_done), 64'd0);
    check({tag, "_wr"}, 64'(a_wr), 64'd0);
    check({tag, "_addr"}, 64'(a_addr), 64'(A_BASE));
    check({tag, "_data"}, 64'(a_data), 64'd0);
    check({tag, "_idx"}, 64'(a_idx), 64'd0);
    check({tag, "_ovr"}, 64'(a_ovr), 64'd0);
    check({tag, "_b_addr"}, 64'(b_addr), 64'(B_BASE));
    check({tag, "_b_idx"}, 64'(b_idx), 64'd0);
    check({tag, "_b_busy"}, 64'(b_busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    logic busy, oeb, ovr;
    logic [7:0] idx;
    repeat (3) tick();
    check_reset_a("por");
    check("adc_clk_high", 64'(a_adc_clk), 64'd1);
    rst_n = 1'b1;
    repeat (2) tick();

    const_mode = 1'b1;
    run_frame(0, NONE, NONE, "A_const");
    const_mode = 1'b0;
    run_frame(0, NONE, 200, "A_overrun");
    run_frame(0, 100, NONE, "A_abort100");
    run_frame(0, NONE, NONE, "A_after_abort");
    run_frame(0, NONE, NONE, "A_rand");

    for (int f = 0; f < 4; f++) run_frame(1, NONE, NONE, $sformatf("B_rand%0d", f));
    run_frame(1, B_PIX, NONE, "B_abort_flush");
    run_frame(1, -2, NONE, "B_abort_lat");
    run_frame(1, 1, NONE, "B_abort_cap1");

    wq_b.delete();
    tick();
    start_b = 1'b1;
    abort_b = 1'b1;
    tick();
    start_b = 1'b0;
    abort_b = 1'b0;
    get_st(1, busy, oeb, ovr, idx);
    check("B_start_abort_busy", 64'(busy), 64'd0);
    repeat (12) tick();
    check("B_start_abort_writes", 64'(wq_b.size()), 64'd0);
    check("B_start_abort_idx", 64'(b_idx), 64'(fidx_b));
    $display("idle start+abort dut=1 busy=%0d writes=%0d", busy, wq_b.size());

    // Reset in the middle of a capture that has already raised overrun and advanced buffer indices.
    run_frame(1, NONE, NONE, "B_pre_reset");
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    s = cyc;
    while (cyc < s + A_LAT + 40) begin
      start_a = (cyc == s + A_LAT + 10);
      tick();
    end
    start_a = 1'b0;
    check("pre_reset_ovr", 64'(a_ovr), 64'd1);
    rst_n = 1'b0;
    tick();
    check_reset_a("mid_reset");
    $display("reset mid-capture dut=0 busy=%0d addr=%0h idx=%0d", a_busy, a_addr, a_idx);
    rst_n = 1'b1;
    fidx_a = 0;
    fidx_b = 0;
    repeat (2) tick();
    run_frame(0, NONE, NONE, "A_post_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_frame_capture.md
ADC_FRAME_CAPTURE -- requirements
Module: adc_frame_capture

Interface
REQ-001 SHALL have parameter LANE_W, default 8, ADC output bus width in bits; one pixel = 2*LANE_W bits.
REQ-002 SHALL have parameter PIX_NUM, default 512, pixels per frame, legal range 1..65535.
REQ-003 SHALL have parameter ADC_LAT, default 4, ADC pipeline latency in clk cycles, legal range 1..15.
REQ-004 SHALL have parameter NUM_BUF, default 2, frame buffers in RAM ring, legal range 1..256.
REQ-005 SHALL have parameter BASE_ADDR, default 32'h0, byte address of buffer 0.
REQ-006 SHALL have port clk, input, 1, system clock; also forwarded as ADC clock.
REQ-007 SHALL have port rst_n, input, 1; reset is synchronous, active-low (rst_n), on clock clk.
REQ-008 SHALL have ports start_i (input, 1, frame request pulse) and abort_i (input, 1, cancel capture).
REQ-009 SHALL have ports adc_clk_o (output, 1, equals clk), adc_data_i (input, LANE_W, DDR data) and adc_oeb_o (output, 1, ADC output enable, active low).
REQ-010 SHALL have ports busy_o (output, 1), done_o (output, 1, frame complete pulse), overrun_o (output, 1, sticky start-while-busy flag) and frame_idx_o (output, 8, current buffer index).
REQ-011 SHALL have ports ram_wr_o (output, 1), ram_addr_o (output, 32, byte address) and ram_data_o (output, 4*LANE_W).

Function
REQ-012 SHALL sample adc_data_i on rising edge (high half) and falling edge (low half) of the same clk period, presenting pixel = {rise, fall} to rising-edge logic.
REQ-013 SHALL implement FSM IDLE -> LAT_WAIT -> CAPTURE -> FLUSH -> IDLE; start_i in IDLE moves to LAT_WAIT next cycle.
REQ-014 SHALL stay ADC_LAT cycles in LAT_WAIT, then exactly PIX_NUM cycles in CAPTURE, capturing one pixel per CAPTURE cycle.
REQ-015 SHALL stay in FLUSH until the final RAM write issues, then return to IDLE and pulse done_o for one cycle in that same cycle.
REQ-016 SHALL pack pixel pairs as ram_data_o = {earlier pixel, later pixel}; ram_wr_o pulses one cycle after the second pixel of a pair is captured.
REQ-017 SHALL, for odd PIX_NUM, write the final word with the lower pixel half zero, one cycle after the last pixel.
REQ-018 SHALL drive ram_addr_o = BASE_ADDR + frame_idx_o*FRAME_BYTES + 4*word_index, FRAME_BYTES = 4*ceil(PIX_NUM/2); addresses advance only on writes.
REQ-019 SHALL increment frame_idx_o on done_o, wrapping from NUM_BUF-1 to 0.
REQ-020 SHALL assert busy_o in every state except IDLE; adc_oeb_o = 0 when busy_o = 1, else 1.
REQ-021 SHALL ignore start_i while busy_o = 1 and set overrun_o; overrun_o clears only when a start_i is accepted in IDLE.
REQ-022 SHALL, on abort_i in any busy state, enter IDLE next cycle with no further writes, no done_o and frame_idx_o unchanged; abort_i wins over simultaneous completion.
REQ-023 SHALL give start_i and abort_i asserted together in IDLE: abort_i priority, no capture started.

Reset
REQ-024 SHALL, with rst_n = 0 at a clk edge, force state IDLE, busy_o 0, adc_oeb_o 1, done_o 0, ram_wr_o 0, ram_addr_o BASE_ADDR, ram_data_o 0, frame_idx_o 0, overrun_o 0, mid-frame included.

Configuration
REQ-025 SHALL, when macro ADC_FRAME_TEST_PATTERN_EN is defined, replace captured pixels with a 2*LANE_W-bit counter starting at 0 each frame, incrementing per CAPTURE cycle, and keep the ADC-data-based path when the macro is undefined; timing is identical in both builds.

Verification
REQ-026 SHALL cover PIX_NUM=512, ADC_LAT=4, rise=8'hA5, fall=8'h3C constant, start pulse -> 256 writes of 32'hA53CA53C at addresses 0x000..0x3FC, done_o 1 cycle after last write, 4+512+1+1 cycles after start.
REQ-027 SHALL cover PIX_NUM=5 with test pattern enabled -> data 0x00000001, 0x00020003, 0x00040000; addresses 0,4,8.
REQ-028 SHALL cover NUM_BUF=2, PIX_NUM=4, three frames -> base addresses 0x0, 0x8, 0x0; frame_idx_o 1, 0, 1 after each done_o.
REQ-029 SHALL cover start_i pulsed during CAPTURE -> overrun_o = 1, frame unaffected; next accepted start -> overrun_o = 0.
REQ-030 SHALL cover abort_i at pixel 100 of 512 -> IDLE next cycle, 50 writes total, no done_o; following frame reuses buffer 0 addresses.
REQ-031 SHALL cover rst_n = 0 during CAPTURE -> all outputs at reset values next edge; subsequent start captures a full frame at BASE_ADDR.
